// File: rtl/core_types_pkg.sv
// Shared types and default latencies for the pipeline control block.
package core_types_pkg;

  localparam int NUM_REGS_DEF    = 32;
  localparam int ALU_READY_DEF   = 1;
  localparam int LOAD_READY_DEF  = 2;
  localparam int FLUSH_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HAZARD  = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } pipe_state_t;

  // Larger of two integers, used to size the readiness countdowns.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Register readiness scoreboard: one countdown per architectural register,
// x0 excluded. A non-zero count means the producer's result is not yet
// forwardable, so a consumer reading it must wait.
import core_types_pkg::*;

module scoreboard #(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int ALU_READY  = ALU_READY_DEF,
  parameter int LOAD_READY = LOAD_READY_DEF,
  parameter int AW         = $clog2(NUM_REGS)
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          i_dec_valid,
  input  logic [AW-1:0] i_rs1,
  input  logic          i_rs1_used,
  input  logic [AW-1:0] i_rs2,
  input  logic          i_rs2_used,
  input  logic          i_issue_we,
  input  logic [AW-1:0] i_rd,
  input  logic          i_is_load,
  input  logic          i_hold,
  output logic          o_hazard
);

  localparam int CW = $clog2(max_int(ALU_READY, LOAD_READY) + 1);

  logic [CW-1:0] r_cnt [NUM_REGS];
  logic          w_rs1_busy;
  logic          w_rs2_busy;

  // Hazard when a used, non-zero source still has a pending producer.
  always_comb begin
    w_rs1_busy = 1'b0;
    w_rs2_busy = 1'b0;
    if (i_rs1_used && (i_rs1 != '0)) begin
      w_rs1_busy = (r_cnt[i_rs1] != '0);
    end else begin
      w_rs1_busy = 1'b0;
    end
    if (i_rs2_used && (i_rs2 != '0)) begin
      w_rs2_busy = (r_cnt[i_rs2] != '0);
    end else begin
      w_rs2_busy = 1'b0;
    end
    o_hazard = i_dec_valid & (w_rs1_busy | w_rs2_busy);
  end

  // Countdowns: issue load wins over decrement; everything holds while frozen.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (!i_hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0) begin
          r_cnt[i] <= '0;
        end else if (i_issue_we && (i_rd == AW'(i))) begin
          r_cnt[i] <= i_is_load ? CW'(LOAD_READY) : CW'(ALU_READY);
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= r_cnt[i];
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: issue/stall/flush/freeze decisions for a DEC->EXE pipe,
// with a small FSM tracking memory waits, hazards and branch flushes.
import core_types_pkg::*;

module pipe_ctrl #(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ALU_READY   = ALU_READY_DEF,
  parameter int LOAD_READY  = LOAD_READY_DEF,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic                        Clock,
  input  logic                        nReset,
  input  logic                        dec_valid,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rs2,
  input  logic                        dec_rs1_used,
  input  logic                        dec_rs2_used,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rd,
  input  logic                        dec_we,
  input  logic                        dec_is_load,
  input  logic                        br_taken,
  input  logic                        mem_busy,
  output logic                        dec_ready,
  output logic                        stall_if,
  output logic                        stall_dec,
  output logic                        bubble_exe,
  output logic                        freeze_all,
  output logic                        flush_if,
  output logic                        flush_dec,
  output logic [1:0]                  state,
  output logic [31:0]                 stall_cycles
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int FW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;
  logic [FW-1:0] r_flush_cnt;
  logic [31:0]   r_stall_cycles;
  logic          w_hazard;
  logic          w_in_flush;
  logic          w_ready;

  scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ALU_READY  (ALU_READY),
    .LOAD_READY (LOAD_READY),
    .AW         (AW)
  ) u_scoreboard (
    .Clock       (Clock),
    .nReset      (nReset),
    .i_dec_valid (dec_valid),
    .i_rs1       (dec_rs1),
    .i_rs1_used  (dec_rs1_used),
    .i_rs2       (dec_rs2),
    .i_rs2_used  (dec_rs2_used),
    .i_issue_we  (w_ready & dec_we),
    .i_rd        (dec_rd),
    .i_is_load   (dec_is_load),
    .i_hold      (mem_busy),
    .o_hazard    (w_hazard)
  );

  // Pipeline control outputs, combinational from inputs and current state.
  always_comb begin
    w_in_flush   = (r_state == ST_FLUSH);
    w_ready      = dec_valid & ~w_hazard & ~mem_busy & ~br_taken & ~w_in_flush;
    dec_ready    = w_ready;
    freeze_all   = mem_busy;
    stall_if     = w_hazard & ~br_taken & ~mem_busy;
    stall_dec    = w_hazard & ~br_taken & ~mem_busy;
    bubble_exe   = (w_hazard | w_in_flush | br_taken) & ~mem_busy;
    flush_if     = (br_taken | w_in_flush) & ~mem_busy;
    flush_dec    = (br_taken | w_in_flush) & ~mem_busy;
    state        = r_state;
    stall_cycles = r_stall_cycles;
  end

  // Next state: memory wait dominates, then branch, then an unfinished flush, then hazard.
  always_comb begin
    w_state_nxt = r_state;
    if (mem_busy) begin
      w_state_nxt = ST_MEMWAIT;
    end else if (br_taken) begin
      w_state_nxt = ST_FLUSH;
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
      w_state_nxt = ST_FLUSH;
    end else if (w_hazard) begin
      w_state_nxt = ST_HAZARD;
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush length counter: (re)loaded by a taken branch, drains while flushing.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_flush_cnt <= '0;
    end else if (mem_busy) begin
      r_flush_cnt <= r_flush_cnt;
    end else if (br_taken) begin
      r_flush_cnt <= FW'(FLUSH_DEPTH - 1);
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
      r_flush_cnt <= r_flush_cnt - 1'b1;
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  // Saturating count of cycles where a valid DEC instruction did not issue.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_stall_cycles <= 32'd0;
    end else if (dec_valid && !w_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle vectors with expected outputs,
// queued when driven and compared mid-cycle.
import core_types_pkg::*;

module tb_pipe_ctrl;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used;
  logic        dec_we, dec_is_load;
  logic        br_taken, mem_busy;
  logic        dec_ready, stall_if, stall_dec, bubble_exe, freeze_all;
  logic        flush_if, flush_dec;
  logic [1:0]  state;
  logic [31:0] stall_cycles;

  typedef struct {
    logic       nrst;
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       br;
    logic       mb;
    logic       e_rdy;
    logic       e_stall;
    logic       e_bub;
    logic       e_frz;
    logic       e_fl;
    logic [1:0] e_st;
    int         e_sc;
  } vec_t;

  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] HAZ = 2'd1;
  localparam logic [1:0] MEM = 2'd2;
  localparam logic [1:0] FLU = 2'd3;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  vec_t exp_q[$];
  vec_t tbl[9];

  pipe_ctrl dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .dec_rd       (dec_rd),
    .dec_we       (dec_we),
    .dec_is_load  (dec_is_load),
    .br_taken     (br_taken),
    .mem_busy     (mem_busy),
    .dec_ready    (dec_ready),
    .stall_if     (stall_if),
    .stall_dec    (stall_dec),
    .bubble_exe   (bubble_exe),
    .freeze_all   (freeze_all),
    .flush_if     (flush_if),
    .flush_dec    (flush_dec),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic nrst, input logic valid,
                              input int rs1, input logic u1, input int rs2, input logic u2,
                              input int rd, input logic we, input logic ld,
                              input logic br, input logic mb,
                              input logic e_rdy, input logic e_stall, input logic e_bub,
                              input logic e_frz, input logic e_fl, input logic [1:0] e_st,
                              input int e_sc);
    vec_t v;
    v.nrst = nrst; v.valid = valid;
    v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
    v.rd = 5'(rd); v.we = we; v.ld = ld; v.br = br; v.mb = mb;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_bub = e_bub;
    v.e_frz = e_frz; v.e_fl = e_fl; v.e_st = e_st; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(input vec_t v);
    vec_t e;
    nReset       = v.nrst;
    dec_valid    = v.valid;
    dec_rs1      = v.rs1;
    dec_rs1_used = v.u1;
    dec_rs2      = v.rs2;
    dec_rs2_used = v.u2;
    dec_rd       = v.rd;
    dec_we       = v.we;
    dec_is_load  = v.ld;
    br_taken     = v.br;
    mem_busy     = v.mb;
    exp_q.push_back(v);
    @(negedge Clock);
    e = exp_q.pop_front();
    check1("dec_ready",  {31'd0, dec_ready},  {31'd0, e.e_rdy});
    check1("stall_if",   {31'd0, stall_if},   {31'd0, e.e_stall});
    check1("stall_dec",  {31'd0, stall_dec},  {31'd0, e.e_stall});
    check1("bubble_exe", {31'd0, bubble_exe}, {31'd0, e.e_bub});
    check1("freeze_all", {31'd0, freeze_all}, {31'd0, e.e_frz});
    check1("flush_if",   {31'd0, flush_if},   {31'd0, e.e_fl});
    check1("flush_dec",  {31'd0, flush_dec},  {31'd0, e.e_fl});
    check1("state",      {30'd0, state},      {30'd0, e.e_st});
    if (e.e_sc >= 0) begin
      check1("stall_cycles", stall_cycles, 32'(e.e_sc));
    end
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  initial begin
    // Reset, then load-use and ALU back-to-back as a table.
    //             nr v  rs1 u1 rs2 u2 rd we ld br mb | rdy stl bub frz fl  st   sc
    tbl[0] = mk(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, RUN, 0);
    tbl[1] = mk(1, 1,  0, 0, 0, 0,  5, 1, 1, 0, 0,  1, 0, 0, 0, 0, RUN, 0);
    tbl[2] = mk(1, 1,  5, 1, 0, 0,  8, 1, 0, 0, 0,  0, 1, 1, 0, 0, RUN, 0);
    tbl[3] = mk(1, 1,  5, 1, 0, 0,  8, 1, 0, 0, 0,  0, 1, 1, 0, 0, HAZ, 1);
    tbl[4] = mk(1, 1,  5, 1, 0, 0,  8, 1, 0, 0, 0,  1, 0, 0, 0, 0, HAZ, 2);
    tbl[5] = mk(1, 1,  1, 1, 0, 0,  6, 1, 0, 0, 0,  1, 0, 0, 0, 0, RUN, 2);
    tbl[6] = mk(1, 1,  0, 0, 6, 1,  9, 1, 0, 0, 0,  0, 1, 1, 0, 0, RUN, 2);
    tbl[7] = mk(1, 1,  0, 0, 6, 1,  9, 1, 0, 0, 0,  1, 0, 0, 0, 0, HAZ, 3);
    tbl[8] = mk(1, 1,  9, 0, 0, 0,  0, 1, 0, 0, 0,  1, 0, 0, 0, 0, RUN, 3);

    nReset = 1'b0; dec_valid = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0; dec_we = 1'b0; dec_is_load = 1'b0;
    br_taken = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge Clock);
    #1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i]);
    end

    // Taken branch with a valid DEC instruction: three flush cycles, no issue.
    step(mk(1, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0,  1, 0, 0, 0, 0, RUN, 3));
    step(mk(1, 1, 0, 0, 0, 0, 11, 1, 1, 1, 0,  0, 0, 1, 0, 1, RUN, 3));
    step(mk(1, 1, 0, 0, 0, 0, 11, 1, 1, 0, 0,  0, 0, 1, 0, 1, FLU, 4));
    step(mk(1, 1, 0, 0, 0, 0, 11, 1, 1, 0, 0,  0, 0, 1, 0, 1, FLU, 5));
    step(mk(1, 1, 11, 1, 0, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0, 0, RUN, 6));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, RUN, 6));

    // Memory freeze with x7 two cycles from ready; branches ignored while busy.
    step(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 0, 0, 0, RUN, 6));
    step(mk(1, 1, 7, 1, 0, 0, 13, 1, 0, 0, 1,  0, 0, 0, 1, 0, RUN, 6));
    step(mk(1, 1, 7, 1, 0, 0, 13, 1, 0, 1, 1,  0, 0, 0, 1, 0, MEM, 7));
    step(mk(1, 1, 7, 1, 0, 0, 13, 1, 0, 0, 1,  0, 0, 0, 1, 0, MEM, 8));
    step(mk(1, 1, 7, 1, 0, 0, 13, 1, 0, 1, 1,  0, 0, 0, 1, 0, MEM, 9));
    step(mk(1, 1, 7, 1, 0, 0, 13, 1, 0, 0, 0,  0, 1, 1, 0, 0, MEM, 10));
    step(mk(1, 1, 7, 1, 0, 0, 13, 1, 0, 0, 0,  0, 1, 1, 0, 0, HAZ, 11));
    step(mk(1, 1, 7, 1, 0, 0, 13, 1, 0, 0, 0,  1, 0, 0, 0, 0, HAZ, 12));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, RUN, 12));

    // x0 is never tracked; branch coinciding with a hazard suppresses stall.
    step(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0, RUN, 12));
    step(mk(1, 1, 0, 1, 0, 1, 14, 1, 0, 0, 0,  1, 0, 0, 0, 0, RUN, 12));
    step(mk(1, 1, 14, 1, 0, 0, 15, 1, 0, 1, 0, 0, 0, 1, 0, 1, RUN, 12));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, FLU, 13));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, FLU, 13));

    // Reset in the middle of a flush with x5 pending.
    step(mk(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0,   1, 0, 0, 0, 0, RUN, 13));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, RUN, 13));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, FLU, 13));
    step(mk(1, 1, 5, 1, 0, 0, 15, 1, 0, 0, 0,  1, 0, 0, 0, 0, RUN, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, RUN, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
